// File: rtl/pe_mem_access_unit.sv
// Bridges PE load/store level requests onto a req/gnt/rvalid data-memory port.
// Handles lane steering, alignment errors, a response timeout and a four-phase ack.
module pe_mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] messReg,
    input  logic [1:0]  mem_size,
    output logic        mem_ack,
    output logic [31:0] load_data,
    output logic        mem_err,
    output logic        busy,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACK} state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] load_q;
    logic        err_q;

    logic        misalign_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane_d;
    logic        timeout_d;

    assign misalign_d = (mem_size == 2'b11)
                      | ((mem_size == 2'b01) & mem_address[0])
                      | ((mem_size == 2'b10) & (|mem_address[1:0]));
    assign timeout_d  = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = messReg;
        case (mem_size)
            2'b00: begin
                be_d    = 4'b0001 << mem_address[1:0];
                wdata_d = {4{messReg[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << mem_address[1:0];
                wdata_d = {2{messReg[15:0]}};
            end
            default: ;
        endcase
    end

    // Loads return the addressed lane zero-extended; sign extension is the PE's job.
    always_comb begin
        lane_d = dmem_rdata;
        case (size_q)
            2'b00: begin
                case (off_q)
                    2'd0:    lane_d = {24'b0, dmem_rdata[7:0]};
                    2'd1:    lane_d = {24'b0, dmem_rdata[15:8]};
                    2'd2:    lane_d = {24'b0, dmem_rdata[23:16]};
                    default: lane_d = {24'b0, dmem_rdata[31:24]};
                endcase
            end
            2'b01:   lane_d = off_q[1] ? {16'b0, dmem_rdata[31:16]} : {16'b0, dmem_rdata[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_write || mem_read) begin
                        off_q  <= mem_address[1:0];
                        size_q <= mem_size;
                        load_q <= '0;
                        cnt_q  <= '0;
                        if (misalign_d) begin
                            err_q   <= 1'b1;
                            state_q <= S_ACK;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= mem_write;
                            addr_q  <= {mem_address[31:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= we_q ? S_ACK : S_WAIT;
                    end else if (timeout_d) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        load_q  <= '0;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        load_q  <= lane_d;
                        state_q <= S_ACK;
                    end else if (timeout_d) begin
                        err_q   <= 1'b1;
                        load_q  <= '0;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    // Four-phase: hold the ack until the PE withdraws both request levels.
                    if (!mem_read && !mem_write) begin
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign mem_ack    = (state_q == S_ACK);
    assign busy       = (state_q != S_IDLE);
    assign mem_err    = err_q;
    assign load_data  = load_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_pe_mem_access_unit.sv
// Randomized and directed bench for pe_mem_access_unit against an arithmetic reference model.
module tb_pe_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_address = '0;
    logic [31:0] messReg = '0;
    logic [1:0]  mem_size = '0;
    logic        mem_ack;
    logic [31:0] load_data;
    logic        mem_err;
    logic        busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int checks = 0;
    int failures = 0;

    pe_mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .messReg(messReg), .mem_size(mem_size),
        .mem_ack(mem_ack), .load_data(load_data), .mem_err(mem_err), .busy(busy),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    // Observations from the most recent transaction
    logic        obs_ack, obs_req_seen, obs_we, obs_err, obs_stable, obs_ack_after;
    logic        obs_busy_after, obs_req_at_ack;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_be;
    int          obs_cycles, obs_gnt_cycle;

    // Reference model: plain arithmetic on byte counts and offsets
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] lane_mask(input int nb);
        return (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    endfunction

    function automatic logic model_illegal(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd3) || ((a % nbytes(s)) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] s, input logic [31:0] a);
        int t;
        t = ((1 << nbytes(s)) - 1) << (a % 4);
        return 4'(t);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] s, input logic [31:0] d);
        logic [31:0] low, w;
        int nb;
        nb  = nbytes(s);
        low = d & lane_mask(nb);
        w   = '0;
        for (int i = 0; i < 4 / nb; i++) w = w | (low << (8 * nb * i));
        return w;
    endfunction

    function automatic logic [31:0] model_lane(input logic [1:0] s, input logic [31:0] a, input logic [31:0] rd);
        return (rd >> (8 * (a % 4))) & lane_mask(nbytes(s));
    endfunction

    // Drives one PE transaction and plays the memory side; records observations only.
    task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] data, input logic [1:0] size,
                              input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                              input int hold);
        int req_cnt, wcnt;
        logic granted;
        obs_ack = 0; obs_req_seen = 0; obs_we = 0; obs_err = 0; obs_stable = 1;
        obs_ack_after = 1; obs_busy_after = 1; obs_req_at_ack = 1;
        obs_addr = '0; obs_wdata = '0; obs_ld = '0; obs_be = '0;
        obs_cycles = 0; obs_gnt_cycle = 0;
        req_cnt = 0; wcnt = 0; granted = 0;
        mem_write = wr; mem_read = rd; mem_address = addr; messReg = data; mem_size = size;
        for (int c = 0; c < 200 && !obs_ack; c++) begin
            @(posedge clk); #1;
            obs_cycles++;
            if (dmem_gnt) begin
                granted = 1; dmem_gnt = 0; obs_gnt_cycle = obs_cycles;
            end
            if (dmem_rvalid) begin
                dmem_rvalid = 0; dmem_rdata = '0;
            end
            if (mem_ack) begin
                obs_ack = 1; obs_err = mem_err; obs_ld = load_data; obs_req_at_ack = dmem_req;
            end else if (dmem_req) begin
                if (!obs_req_seen) begin
                    obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata; obs_we = dmem_we;
                end
                obs_req_seen = 1;
                if (req_cnt == gnt_dly) dmem_gnt = 1;
                req_cnt++;
            end else if (granted) begin
                if (rv_dly >= 0 && wcnt == rv_dly) begin
                    dmem_rvalid = 1; dmem_rdata = rdata;
                end
                wcnt++;
            end
        end
        dmem_gnt = 0;
        // Stray memory responses during ACK must not disturb the result
        dmem_rvalid = 1; dmem_rdata = $urandom;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!mem_ack || load_data !== obs_ld || mem_err !== obs_err) obs_stable = 0;
        end
        dmem_rvalid = 0; dmem_rdata = '0;
        mem_write = 0; mem_read = 0;
        @(posedge clk); #1;
        obs_ack_after = mem_ack; obs_busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1; mem_read = 1; mem_size = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_ack, mem_err, busy, dmem_req, dmem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got ack=%b err=%b busy=%b req=%b we=%b exp all 0", mem_ack, mem_err, busy, dmem_req, dmem_we);
        end
        checks++;
        if (load_data !== 32'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_be !== 4'h0) begin
            failures++;
            $display("FAIL reset_data got ld=%h addr=%h wdata=%h be=%b exp 0", load_data, dmem_addr, dmem_wdata, dmem_be);
        end
        mem_read = 0;
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_lh();
        run_access(0, 1, 32'h0000_0026, 32'h0, 2'b01, 1, 0, 32'h80A5_1234, 2);
        checks++;
        if (obs_ack !== 1'b1 || obs_err !== 1'b0) begin
            failures++; $display("FAIL lh_ack got ack=%b err=%b exp ack=1 err=0", obs_ack, obs_err);
        end
        checks++;
        if (obs_ld !== 32'h0000_80A5) begin
            failures++; $display("FAIL lh_data got %h exp 000080a5", obs_ld);
        end
        checks++;
        if (obs_addr !== 32'h0000_0024 || obs_we !== 1'b0) begin
            failures++; $display("FAIL lh_addr got addr=%h we=%b exp 00000024 we=0", obs_addr, obs_we);
        end
    endtask

    task automatic test_sb();
        run_access(1, 0, 32'h0000_0103, 32'h0000_00AB, 2'b00, 0, -1, 32'h0, 3);
        checks++;
        if (obs_we !== 1'b1 || obs_be !== 4'b1000 || obs_addr !== 32'h0000_0100) begin
            failures++; $display("FAIL sb_req got we=%b be=%b addr=%h exp we=1 be=1000 addr=00000100", obs_we, obs_be, obs_addr);
        end
        checks++;
        if (obs_wdata !== 32'hABAB_ABAB) begin
            failures++; $display("FAIL sb_wdata got %h exp abababab", obs_wdata);
        end
        checks++;
        if (obs_ack !== 1'b1 || obs_err !== 1'b0 || obs_stable !== 1'b1) begin
            failures++; $display("FAIL sb_ack_hold got ack=%b err=%b stable=%b exp 1 0 1", obs_ack, obs_err, obs_stable);
        end
        checks++;
        if (obs_ack_after !== 1'b0 || obs_busy_after !== 1'b0) begin
            failures++; $display("FAIL sb_ack_release got ack=%b busy=%b exp 0 0", obs_ack_after, obs_busy_after);
        end
    endtask

    task automatic test_misaligned();
        run_access(0, 1, 32'h0000_0002, 32'h0, 2'b10, 0, 0, 32'hDEAD_BEEF, 1);
        checks++;
        if (obs_req_seen !== 1'b0) begin
            failures++; $display("FAIL misalign_noreq got req_seen=%b exp 0", obs_req_seen);
        end
        checks++;
        if (obs_ack !== 1'b1 || obs_err !== 1'b1 || obs_cycles != 1) begin
            failures++; $display("FAIL misalign_ack got ack=%b err=%b cycles=%0d exp 1 1 1", obs_ack, obs_err, obs_cycles);
        end
    endtask

    task automatic test_timeout();
        run_access(0, 1, 32'h0000_0080, 32'h0, 2'b10, 0, -1, 32'h0, 1);
        checks++;
        if (obs_ack !== 1'b1 || obs_err !== 1'b1 || obs_ld !== 32'h0 || obs_req_at_ack !== 1'b0) begin
            failures++;
            $display("FAIL timeout_result got ack=%b err=%b ld=%h req=%b exp 1 1 0 0", obs_ack, obs_err, obs_ld, obs_req_at_ack);
        end
        checks++;
        if (obs_cycles - obs_gnt_cycle != TIMEOUT) begin
            failures++; $display("FAIL timeout_cycles got %0d exp %0d", obs_cycles - obs_gnt_cycle, TIMEOUT);
        end
    endtask

    task automatic test_reset_wait();
        logic got_req;
        logic was_busy;
        got_req = 0;
        mem_read = 1; mem_address = 32'h0000_0010; mem_size = 2'b10;
        for (int c = 0; c < 20 && !got_req; c++) begin
            @(posedge clk); #1;
            if (dmem_req) got_req = 1;
        end
        dmem_gnt = 1;
        @(posedge clk); #1;
        dmem_gnt = 0;
        was_busy = busy && !dmem_req && !mem_ack;
        checks++;
        if (!got_req || !was_busy) begin
            failures++; $display("FAIL rstwait_enter got req=%b in_wait=%b exp 1 1", got_req, was_busy);
        end
        reset = 1; mem_read = 0;
        @(posedge clk); #1;
        reset = 0;
        dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_rvalid = 0; dmem_rdata = '0;
        checks++;
        if (mem_ack !== 1'b0 || load_data !== 32'h0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstwait_discard got ack=%b ld=%h busy=%b exp 0 0 0", mem_ack, load_data, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_ack !== 1'b0 || load_data !== 32'h0) begin
            failures++; $display("FAIL rstwait_settle got ack=%b ld=%h exp 0 0", mem_ack, load_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        run_access(1, 1, 32'h0000_0040, 32'h1234_5678, 2'b10, 0, 0, 32'h0, 1);
        checks++;
        if (obs_we !== 1'b1 || obs_be !== 4'b1111 || obs_wdata !== 32'h1234_5678 || obs_ack !== 1'b1) begin
            failures++;
            $display("FAIL both_write got we=%b be=%b wdata=%h ack=%b exp 1 1111 12345678 1", obs_we, obs_be, obs_wdata, obs_ack);
        end
        rd = $urandom;
        run_access(0, 1, 32'h0000_0044, 32'h0, 2'b10, 2, 1, rd, 0);
        checks++;
        if (obs_we !== 1'b0 || obs_ld !== rd || obs_err !== 1'b0) begin
            failures++; $display("FAIL b2b_read got we=%b ld=%h err=%b exp 0 %h 0", obs_we, obs_ld, obs_err, rd);
        end
    endtask

    task automatic test_random();
        logic wr;
        logic [1:0] sz;
        logic [31:0] a, d, rd;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz) - 1));
            d  = $urandom;
            rd = $urandom;
            run_access(wr, !wr, a, d, sz, $urandom_range(0, 3), $urandom_range(0, 3), rd, $urandom_range(0, 2));
            checks++;
            if (obs_ack !== 1'b1 || obs_stable !== 1'b1 || obs_ack_after !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_handshake got ack=%b stable=%b after=%b exp 1 1 0", i, obs_ack, obs_stable, obs_ack_after);
            end
            if (model_illegal(sz, a)) begin
                checks++;
                if (obs_req_seen !== 1'b0 || obs_err !== 1'b1 || obs_ld !== 32'h0) begin
                    failures++;
                    $display("FAIL rand%0d_illegal a=%h sz=%0d got req=%b err=%b ld=%h exp 0 1 0", i, a, sz, obs_req_seen, obs_err, obs_ld);
                end
            end else begin
                checks++;
                if (obs_err !== 1'b0 || obs_we !== wr || obs_addr !== (a & 32'hFFFF_FFFC) || obs_be !== model_be(sz, a)) begin
                    failures++;
                    $display("FAIL rand%0d_req got err=%b we=%b addr=%h be=%b exp 0 %b %h %b", i, obs_err, obs_we, obs_addr, obs_be,
                             wr, a & 32'hFFFF_FFFC, model_be(sz, a));
                end
                checks++;
                if (wr && obs_wdata !== model_wdata(sz, d)) begin
                    failures++; $display("FAIL rand%0d_wdata got %h exp %h", i, obs_wdata, model_wdata(sz, d));
                end else if (!wr && obs_ld !== model_lane(sz, a, rd)) begin
                    failures++; $display("FAIL rand%0d_load got %h exp %h", i, obs_ld, model_lane(sz, a, rd));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lh();
        test_sb();
        test_misaligned();
        test_timeout();
        test_reset_wait();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
